// File: rtl/sigma_np_acc_if.sv
// sigma_np_acc_if: sample-side and result-side signals of the windowed accumulator
interface sigma_np_acc_if #(
  parameter int DW    = 8,
  parameter int LOG2N = 4
);
  localparam int OW = DW + LOG2N;
  logic [DW-1:0] data_in;
  logic          en;
  logic          syn_in;
  logic [OW-1:0] data_out;
  logic          syn_out;
  logic          busy;
  logic          err;
  modport master (output data_in, en, syn_in, input data_out, syn_out, busy, err);
  modport slave  (input data_in, en, syn_in, output data_out, syn_out, busy, err);
endinterface

// File: rtl/sigma_np_acc.sv
// sigma_np_acc: sums 2^LOG2N valid samples after each syn_in rise, reports result/abort
module sigma_np_acc #(
  parameter int DW     = 8,
  parameter int LOG2N  = 4,
  parameter int SIGNED = 0,
  parameter int AVG    = 0
) (
  input logic          clk,
  input logic          res,
  sigma_np_acc_if.slave s
);
  localparam int OW = DW + LOG2N;
  localparam int N  = 1 << LOG2N;
  localparam logic [LOG2N:0] CMAX = (LOG2N + 1)'(N - 1);
  typedef enum logic {IDLE, ACC} state_t;
  state_t r_state, w_next;
  logic                  r_syn_d, r_syn_out, r_err;
  logic [OW-1:0]         r_acc, r_data;
  logic [LOG2N:0]        r_cnt;
  logic                  w_rise, w_last;
  logic [OW-1:0]         w_x, w_sum, w_sh, w_f;
  logic signed [OW-1:0]  w_ss;
  assign w_rise = s.syn_in & ~r_syn_d;
  assign w_last = (r_state == ACC) && !w_rise && s.en && (r_cnt == CMAX);
  assign w_x    = (SIGNED != 0) ? {{LOG2N{s.data_in[DW-1]}}, s.data_in} : {{LOG2N{1'b0}}, s.data_in};
  assign w_sum  = r_acc + w_x;
  // kept separate so the shift sees a purely signed operand and stays arithmetic
  assign w_ss   = $signed(w_sum) >>> LOG2N;
  assign w_sh   = (SIGNED != 0) ? w_ss : (w_sum >> LOG2N);
  assign w_f    = (AVG != 0) ? w_sh : w_sum;
  // state register
  always_ff @(posedge clk or posedge res)
    if (res) r_state <= IDLE;
    else r_state <= w_next;
  // a rise always (re)opens a window; the last sample closes it
  always_comb w_next = w_rise ? ACC : w_last ? IDLE : r_state;
  // edge detector, accumulator, sample counter and registered result
  always_ff @(posedge clk or posedge res)
    if (res) begin
      r_syn_d   <= 1'b0;
      r_syn_out <= 1'b0;
      r_err     <= 1'b0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_data    <= '0;
    end else begin
      r_syn_d   <= s.syn_in;
      r_syn_out <= w_last;
      r_err     <= w_rise && (r_state == ACC);
      if (w_rise) begin
        r_acc <= s.en ? w_x : '0;
        r_cnt <= s.en ? (LOG2N + 1)'(1) : '0;
      end else if (w_last) begin
        r_data <= w_f;
        r_acc  <= '0;
        r_cnt  <= '0;
      end else if (r_state == ACC && s.en) begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  // outputs
  always_comb begin
    s.busy     = r_state == ACC;
    s.syn_out  = r_syn_out;
    s.err      = r_err;
    s.data_out = r_data;
  end
endmodule

// File: tb/tb_sigma_np_acc.sv
// tb_sigma_np_acc: four configurations (U, S, U-avg, S-avg) on shared stimulus vs window model
module tb_sigma_np_acc;
  localparam int N = 16;
  logic clk = 0, res = 1, en = 0, syn_in = 0;
  logic [7:0] data_in = 0;
  logic [14:0] got [4];
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : gd
    sigma_np_acc_if #(.DW(8), .LOG2N(4)) b ();
    assign b.data_in = data_in;
    assign b.en      = en;
    assign b.syn_in  = syn_in;
    sigma_np_acc #(.DW(8), .LOG2N(4), .SIGNED(g % 2), .AVG(g / 2)) u (.clk(clk), .res(res), .s(b));
    assign got[g] = {b.busy, b.err, b.syn_out, b.data_out};
  end
  int q[$];
  bit open, prev, ee, es;
  logic [11:0] ed [4];
  function automatic void model_reset();
    open = 0; prev = 0; ee = 0; es = 0; q.delete();
    for (int c = 0; c < 4; c++) ed[c] = '0;
  endfunction
  function automatic void model_step();
    bit rise;
    int su, ss;
    rise = syn_in && !prev;
    ee = 0; es = 0;
    if (rise) begin
      ee = open; open = 1; q.delete();
      if (en) q.push_back(int'(data_in));
    end else if (open && en) begin
      q.push_back(int'(data_in));
      if (q.size() == N) begin
        su = 0; ss = 0;
        foreach (q[i]) begin
          su += q[i];
          ss += (q[i] >= 128) ? q[i] - 256 : q[i];
        end
        ed[0] = su[11:0];
        ed[1] = ss[11:0];
        su = su / N;
        ss = ss >>> 4;
        ed[2] = su[11:0];
        ed[3] = ss[11:0];
        open = 0; es = 1; q.delete();
      end
    end
    prev = syn_in;
  endfunction
  function automatic void chk(string name, logic [14:0] a, logic [14:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endfunction
  function automatic void check_all(string name);
    for (int c = 0; c < 4; c++) chk($sformatf("%s cfg%0d", name, c), got[c], {open, ee, es, ed[c]});
  endfunction
  task automatic tick(input logic s, input logic e, input logic [7:0] d, input string name);
    syn_in = s; en = e; data_in = d;
    @(posedge clk);
    model_step();
    #1 check_all(name);
  endtask
  typedef struct {
    logic [7:0]  a, b;
    logic [11:0] eu, es, eua, esa;
  } vec_t;
  vec_t vt [6];
  initial begin
    vt[0] = '{8'h01, 8'h01, 12'h010, 12'h010, 12'h001, 12'h001};
    vt[1] = '{8'hFF, 8'hFF, 12'hFF0, 12'hFF0, 12'h0FF, 12'hFFF};
    vt[2] = '{8'h80, 8'h80, 12'h800, 12'h800, 12'h080, 12'hF80};
    vt[3] = '{8'h03, 8'h05, 12'h040, 12'h040, 12'h004, 12'h004};
    vt[4] = '{8'hFD, 8'hFD, 12'hFD0, 12'hFD0, 12'h0FD, 12'hFFD};
    vt[5] = '{8'h7F, 8'h80, 12'h7F8, 12'hFF8, 12'h07F, 12'hFFF};
    model_reset();
    #2 check_all("reset");
    #15 res = 0;
    for (int i = 0; i < 60; i++) tick(((i / 10) % 2) == 1, 1, 1, "toggle");
    tick(0, 0, 0, "idle");
    foreach (vt[v]) begin
      tick(0, 0, 0, "tbl_gap");
      for (int i = 0; i < N; i++) tick(1, 1, (i % 2) ? vt[v].b : vt[v].a, "tbl_win");
      chk($sformatf("tbl%0d u", v), got[0], {3'b001, vt[v].eu});
      chk($sformatf("tbl%0d s", v), got[1], {3'b001, vt[v].es});
      chk($sformatf("tbl%0d ua", v), got[2], {3'b001, vt[v].eua});
      chk($sformatf("tbl%0d sa", v), got[3], {3'b001, vt[v].esa});
    end
    tick(0, 0, 0, "gap_pre");
    tick(1, 0, 2, "gap_rise");
    for (int k = 0, i = 1; k < N; i++) begin
      tick(1, (i % 3) == 0, 2, "gap");
      if ((i % 3) == 0) k++;
    end
    chk("gap_done", got[0], {3'b001, 12'd32});
    for (int i = 0; i < 20; i++) tick(1, 1, 9, "held_high");
    tick(0, 0, 0, "abort_pre");
    for (int i = 0; i < 7; i++) tick(1, 1, 1, "abort_win");
    tick(0, 1, 1, "abort_low");
    chk("abort_hold", got[0], {3'b100, 12'd32});
    tick(1, 1, 1, "abort_rise");
    chk("abort_err", got[0], {3'b110, 12'd32});
    for (int i = 0; i < N - 1; i++) tick(1, 1, 1, "abort_new");
    chk("abort_done", got[0], {3'b001, 12'd16});
    tick(0, 0, 0, "b2b_pre");
    for (int i = 0; i < N - 1; i++) tick(1, 1, 3, "b2b_a");
    tick(0, 1, 3, "b2b_last");
    tick(1, 1, 4, "b2b_rise");
    chk("b2b_noerr", got[0], {3'b100, 12'd48});
    for (int i = 0; i < N - 1; i++) tick(1, 1, 4, "b2b_b");
    tick(0, 0, 0, "rst_pre");
    for (int i = 0; i < 9; i++) tick(1, 1, 5, "rst_win");
    res = 1;
    model_reset();
    #1 check_all("rst_async");
    @(posedge clk);
    #1 check_all("rst_hold");
    res = 0;
    for (int i = 0; i < N; i++) tick(1, 1, 1, "rst_after");
    chk("rst_after_done", got[0], {3'b001, 12'd16});
    for (int i = 0; i < 3000; i++)
      tick(($urandom_range(0, 19) == 0) ? !syn_in : syn_in, $urandom_range(0, 3) != 0, 8'($urandom), "rand");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
